// File: rtl/spi_slave_param.sv
// rtl/spi_slave_param.sv - parametrised SPI slave front end with abort, missing-address and tx timeout checks
// Define SPI_PARITY_EN to add an odd parity bit to the MOSI frame and to the MISO payload.
module spi_slave_param #(
   parameter int PAYLOAD_W  = 8,
   parameter int TX_TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 SS_n,
   input  logic                 MOSI,
   output logic                 MISO,
   output logic [PAYLOAD_W+1:0] rx_data,
   output logic                 rx_valid,
   input  logic [PAYLOAD_W-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 busy,
   output logic                 frame_err
);
   localparam int FW = PAYLOAD_W + 2;
`ifdef SPI_PARITY_EN
   localparam int NBITS  = FW + 1;
   localparam int TXBITS = PAYLOAD_W + 1;
`else
   localparam int NBITS  = FW;
   localparam int TXBITS = PAYLOAD_W;
`endif
   localparam int CMAX_A = (NBITS > TXBITS) ? NBITS : TXBITS;
   localparam int CMAX   = (CMAX_A > TX_TIMEOUT) ? CMAX_A : TX_TIMEOUT;
   localparam int CW     = $clog2(CMAX + 1);
   localparam logic [CW-1:0] RX_LAST  = CW'(NBITS - 1);
   localparam logic [CW-1:0] TO_LAST  = CW'(TX_TIMEOUT - 1);
   localparam logic [CW-1:0] DATA_END = CW'(PAYLOAD_W);

   typedef enum logic [2:0] {IDLE, RECV, WAIT_TX, SEND, DONE} state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [NBITS-2:0]       rx_sh_q, rx_sh_d;
   logic [PAYLOAD_W-1:0]   tx_sh_q, tx_sh_d;
   logic [FW-1:0]          rx_data_q, rx_data_d;
   logic                   rx_valid_q, rx_valid_d;
   logic                   frame_err_q, frame_err_d;
   logic                   miso_q, miso_d;
   logic                   busy_q, busy_d;
   logic                   addr_seen_q, addr_seen_d;
`ifdef SPI_PARITY_EN
   logic                   tx_par_q, tx_par_d;
`endif
   logic [NBITS-1:0]       word;
   logic [FW-1:0]          frame;
   logic                   parity_bad;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rx_sh_d     = rx_sh_q;
      tx_sh_d     = tx_sh_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;
      miso_d      = miso_q;
      addr_seen_d = addr_seen_q;
`ifdef SPI_PARITY_EN
      tx_par_d    = tx_par_q;
`endif
      word  = {rx_sh_q, MOSI};
      frame = word[NBITS-1 -: FW];
`ifdef SPI_PARITY_EN
      parity_bad = ~(^word);
`else
      parity_bad = 1'b0;
`endif
      // Deselect wins over everything; only a completed transfer (DONE) ends silently.
      if (state_q != IDLE && SS_n) begin
         state_d     = IDLE;
         miso_d      = 1'b0;
         cnt_d       = '0;
         frame_err_d = (state_q != DONE);
      end else begin
         case (state_q)
            IDLE: begin
               if (!SS_n) begin
                  state_d = RECV;
                  rx_sh_d = {rx_sh_q[NBITS-3:0], MOSI};
                  cnt_d   = CW'(1);
               end
            end
            RECV: begin
               if (cnt_q == RX_LAST) begin
                  cnt_d   = '0;
                  state_d = DONE;
                  if (parity_bad || (frame[FW-1:FW-2] == 2'b11 && !addr_seen_q)) begin
                     frame_err_d = 1'b1;
                  end else begin
                     rx_data_d  = frame;
                     rx_valid_d = 1'b1;
                     if (frame[FW-1:FW-2] == 2'b10) addr_seen_d = 1'b1;
                     if (frame[FW-1:FW-2] == 2'b11) state_d = WAIT_TX;
                  end
               end else begin
                  rx_sh_d = {rx_sh_q[NBITS-3:0], MOSI};
                  cnt_d   = cnt_q + 1'b1;
               end
            end
            WAIT_TX: begin
               if (tx_valid) begin
                  tx_sh_d = tx_data << 1;
                  miso_d  = tx_data[PAYLOAD_W-1];
                  cnt_d   = CW'(1);
                  state_d = SEND;
`ifdef SPI_PARITY_EN
                  tx_par_d = ~(^tx_data);
`endif
               end else if (cnt_q == TO_LAST) begin
                  frame_err_d = 1'b1;
                  cnt_d       = '0;
                  state_d     = DONE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            SEND: begin
               if (cnt_q < DATA_END) begin
                  miso_d  = tx_sh_q[PAYLOAD_W-1];
                  tx_sh_d = tx_sh_q << 1;
                  cnt_d   = cnt_q + 1'b1;
`ifdef SPI_PARITY_EN
               end else if (cnt_q == DATA_END) begin
                  miso_d = tx_par_q;
                  cnt_d  = cnt_q + 1'b1;
`endif
               end else begin
                  miso_d      = 1'b0;
                  addr_seen_d = 1'b0;
                  cnt_d       = '0;
                  state_d     = DONE;
               end
            end
            DONE:    ;
            default: state_d = IDLE;
         endcase
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rx_sh_q     <= '0;
         tx_sh_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         miso_q      <= 1'b0;
         busy_q      <= 1'b0;
         addr_seen_q <= 1'b0;
`ifdef SPI_PARITY_EN
         tx_par_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rx_sh_q     <= rx_sh_d;
         tx_sh_q     <= tx_sh_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         miso_q      <= miso_d;
         busy_q      <= busy_d;
         addr_seen_q <= addr_seen_d;
`ifdef SPI_PARITY_EN
         tx_par_q    <= tx_par_d;
`endif
      end
   end

   assign MISO      = miso_q;
   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_spi_slave_param.sv
// tb/tb_spi_slave_param.sv - directed plus randomized frame bench for spi_slave_param
// Follows SPI_PARITY_EN when defined so frames and MISO payloads carry the parity bit.
module tb_spi_slave_param;
   localparam int PW = 8;
   localparam int TO = 16;
   localparam int FW = PW + 2;
`ifdef SPI_PARITY_EN
   localparam int NB = FW + 1;
`else
   localparam int NB = FW;
`endif

   logic          clk;
   logic          rst;
   logic          SS_n;
   logic          MOSI;
   logic          MISO;
   logic [FW-1:0] rx_data;
   logic          rx_valid;
   logic [PW-1:0] tx_data;
   logic          tx_valid;
   logic          busy;
   logic          frame_err;

   int            checks   = 0;
   int            failures = 0;
   logic [FW-1:0] rx_data_m;
   bit            addr_seen_m;

   spi_slave_param #(.PAYLOAD_W(PW), .TX_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
      .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
      .tx_valid(tx_valid), .busy(busy), .frame_err(frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic noise();
      tx_valid = 1'($urandom_range(0, 1));
      tx_data  = PW'($urandom);
   endtask

   // One SPI transaction: nsent frame bits (< NB aborts), then response and DONE tail.
   task automatic run_frame(input logic [1:0] cmd, input logic [PW-1:0] pl, input int nsent,
                            input bit bad_par, input int tv_delay, input logic [PW-1:0] txd);
      logic [FW-1:0] fr;
      logic [NB-1:0] w;
      bit            par_ok;
      bit            wait_tx;
      bit            sent;
      bit            q[$];
      fr     = {cmd, pl};
      par_ok = (bad_par == 1'b0);
`ifdef SPI_PARITY_EN
      w = {fr, ~(^fr) ^ bad_par};
`else
      w = fr;
`endif
      for (int k = 1; k <= nsent && k <= NB; k++) begin
         SS_n = 1'b0;
         MOSI = w[NB-k];
         noise();
         tick();
         if (k < NB) begin
            chk("recv_busy", busy, 1);
            chk("recv_rxv", rx_valid, 0);
            chk("recv_err", frame_err, 0);
            chk("recv_miso", MISO, 0);
         end
      end
      if (nsent < NB) begin
         SS_n = 1'b1;
         MOSI = 1'($urandom);
         noise();
         tick();
         chk("abort_err", frame_err, 1);
         chk("abort_rxv", rx_valid, 0);
         chk("abort_busy", busy, 0);
         chk("abort_rxd", rx_data, rx_data_m);
         tick();
         chk("abort_err_pulse", frame_err, 0);
         return;
      end
      if (!par_ok || (cmd == 2'b11 && !addr_seen_m)) begin
         chk("dec_err", frame_err, 1);
         chk("dec_rxv", rx_valid, 0);
         chk("dec_rxd_hold", rx_data, rx_data_m);
         wait_tx = 1'b0;
      end else begin
         rx_data_m = fr;
         chk("dec_rxv", rx_valid, 1);
         chk("dec_err", frame_err, 0);
         chk("dec_rxd", rx_data, rx_data_m);
         if (cmd == 2'b10) addr_seen_m = 1'b1;
         wait_tx = (cmd == 2'b11);
      end
      chk("dec_busy", busy, 1);
      chk("dec_miso", MISO, 0);
      sent = 1'b0;
      if (wait_tx) begin
         for (int e = 1; e <= TO && !sent; e++) begin
            SS_n     = 1'b0;
            MOSI     = 1'($urandom);
            tx_valid = (e == tv_delay + 1);
            tx_data  = tx_valid ? txd : PW'($urandom);
            tick();
            chk("wait_rxv", rx_valid, 0);
            if (tx_valid) sent = 1'b1;
            else begin
               chk("wait_miso", MISO, 0);
               chk("wait_err", frame_err, (e == TO));
            end
         end
      end
      if (sent) begin
         for (int i = 0; i < PW; i++) q.push_back(txd[PW-1-i]);
`ifdef SPI_PARITY_EN
         q.push_back(~(^txd));
`endif
         q.push_back(1'b0);
         foreach (q[i]) begin
            if (i > 0) begin
               SS_n = 1'b0;
               MOSI = 1'($urandom);
               noise();
               tick();
            end
            chk("send_miso", MISO, q[i]);
            chk("send_err", frame_err, 0);
            chk("send_busy", busy, 1);
         end
         addr_seen_m = 1'b0;
      end
      for (int d = 0; d < 2; d++) begin
         SS_n = 1'b0;
         MOSI = 1'($urandom);
         noise();
         tick();
         chk("done_busy", busy, 1);
         chk("done_err", frame_err, 0);
         chk("done_rxv", rx_valid, 0);
         chk("done_miso", MISO, 0);
      end
      SS_n = 1'b1;
      noise();
      tick();
      chk("end_busy", busy, 0);
      chk("end_err", frame_err, 0);
      chk("end_rxd", rx_data, rx_data_m);
   endtask

   initial begin
      logic [1:0]    cmd;
      logic [PW-1:0] pl;
      int            ns;
      bit            bp;
      rst = 1'b1; SS_n = 1'b0; MOSI = 1'b1; tx_valid = 1'b1; tx_data = 8'hFF;
      rx_data_m = '0; addr_seen_m = 1'b0;
      tick();
      chk("rst_miso", MISO, 0);
      chk("rst_rxd", rx_data, 0);
      chk("rst_rxv", rx_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", frame_err, 0);
      rst = 1'b0; SS_n = 1'b1; tx_valid = 1'b0;
      tick();
      chk("idle_busy", busy, 0);

      run_frame(2'b00, 8'hA5, NB, 1'b0, 0, 8'h00);
      run_frame(2'b10, 8'h07, NB, 1'b0, 0, 8'h00);
      run_frame(2'b11, 8'h5A, NB, 1'b0, 1, 8'hC3);
      run_frame(2'b11, 8'h12, NB, 1'b0, 0, 8'h00);
      run_frame(2'b01, 8'h3C, 5,  1'b0, 0, 8'h00);
      run_frame(2'b01, 8'h3C, NB, 1'b0, 0, 8'h00);
      run_frame(2'b10, 8'h44, NB, 1'b0, 0, 8'h00);
      run_frame(2'b11, 8'h99, NB, 1'b0, TO + 4, 8'hFF);
      run_frame(2'b10, 8'h81, NB - 1, 1'b0, 0, 8'h00);
      run_frame(2'b11, 8'h01, NB, 1'b0, 0, 8'h81);
      run_frame(2'b10, 8'h02, NB, 1'b0, 0, 8'h00);
      run_frame(2'b11, 8'h03, NB, 1'b0, TO - 1, 8'h6D);
`ifdef SPI_PARITY_EN
      run_frame(2'b00, 8'hA5, NB, 1'b1, 0, 8'h00);
      run_frame(2'b00, 8'hA5, NB, 1'b0, 0, 8'h00);
`endif

      for (int n = 0; n < 40; n++) begin
         cmd = 2'($urandom);
         pl  = PW'($urandom);
         ns  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, NB - 1) : NB;
`ifdef SPI_PARITY_EN
         bp  = ($urandom_range(0, 4) == 0);
`else
         bp  = 1'b0;
`endif
         run_frame(cmd, pl, ns, bp, $urandom_range(0, TO + 2), PW'($urandom));
      end

      run_frame(2'b10, 8'h55, NB, 1'b0, 0, 8'h00);
      SS_n = 1'b0;
      for (int k = 0; k < 4; k++) begin
         MOSI = 1'($urandom);
         tick();
      end
      rst = 1'b1;
      tick();
      rx_data_m = '0; addr_seen_m = 1'b0;
      chk("midrst_busy", busy, 0);
      chk("midrst_rxd", rx_data, 0);
      chk("midrst_miso", MISO, 0);
      chk("midrst_err", frame_err, 0);
      rst = 1'b0; SS_n = 1'b1;
      tick();
      run_frame(2'b11, 8'h77, NB, 1'b0, 0, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
